// File: rtl/logistic_pkg.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | logistic_pkg : shared types, width helpers and seed function for the     |
// |                logistic-map iteration scheduler.  Rev 1.0                |
// +-------------------------------------------------------------------------+
package logistic_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    MUL_Y  = 3'd1,
    MUL_Z  = 3'd2,
    WRITE  = 3'd3,
    R_STEP = 3'd4
  } state_t;

  localparam int unsigned FRAC_DEFAULT = 16;
  localparam logic [31:0] ONE = 32'd1 << FRAC_DEFAULT;

  function automatic int unsigned x_width(input int unsigned frac);
    return frac;
  endfunction

  function automatic int unsigned r_width(input int unsigned frac);
    return frac + 2;
  endfunction

  function automatic int unsigned b_width(input int unsigned frac);
    return frac + 1;
  endfunction

  function automatic int unsigned p_width(input int unsigned frac);
    return 2 * frac + 3;
  endfunction

  function automatic logic [31:0] one_val(input int unsigned frac);
    return 32'd1 << frac;
  endfunction

  // A zero seed would pin the slot to the map's fixed point, so it becomes 1.
  function automatic logic [31:0] seed_x(input int unsigned base, input int unsigned step,
                                         input int unsigned idx, input int unsigned frac);
    logic [31:0] v;
    v = (base + idx * step) & (one_val(frac) - 32'd1);
    if (v == 32'd0) v = 32'd1;
    return v;
  endfunction

endpackage
`default_nettype wire

// File: rtl/logistic_iter_sched_timer.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | logistic_frame_timer : free-running frame counter, one-cycle tick at the |
// |                        terminal count, frozen while disabled.  Rev 1.0   |
// +-------------------------------------------------------------------------+
module logistic_frame_timer #(
  parameter int unsigned ITER_LEN = 15361
) (
  input  logic clk,
  input  logic reset,
  input  logic i_enable,
  output logic o_tick
);

  localparam int unsigned CNT_W = (ITER_LEN > 1) ? $clog2(ITER_LEN) : 1;
  localparam logic [CNT_W-1:0] C_LAST = CNT_W'(ITER_LEN - 1);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt <= '0;
    end else if (i_enable) begin
      r_cnt <= (r_cnt == C_LAST) ? '0 : r_cnt + CNT_W'(1);
    end
  end

  // Gated by enable so a frozen counter parked on the last value cannot repeat the tick.
  assign o_tick = i_enable && (r_cnt == C_LAST);

endmodule
`default_nettype wire

// File: rtl/logistic_iter_sched.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | logistic_iter_sched : per-frame sweep of x' = r*x*(1-x) over all slots   |
// |                       through a shared req/ack multiplier.  Rev 1.0      |
// +-------------------------------------------------------------------------+
module logistic_iter_sched
  import logistic_pkg::*;
#(
  parameter int unsigned N_OSC     = 8,
  parameter int unsigned ITER_LEN  = 15361,
  parameter int unsigned FRAC      = 16,
  parameter int unsigned R_INIT    = 3 << FRAC,
  parameter int unsigned R_MAX     = (4 << FRAC) - 1,
  parameter int unsigned R_INC     = 2,
  parameter int unsigned SEED_BASE = 32'h8000,
  parameter int unsigned SEED_STEP = 32'h0101,
  localparam int unsigned IDX_W    = (N_OSC > 1) ? $clog2(N_OSC) : 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  i_enable,
  output logic                  o_mul_req,
  output logic [FRAC+1:0]       o_mul_a,
  output logic [FRAC:0]         o_mul_b,
  input  logic                  i_mul_ack,
  input  logic [2*FRAC+2:0]     i_mul_p,
  output logic                  o_upd_valid,
  output logic [IDX_W-1:0]      o_upd_idx,
  output logic [FRAC-1:0]       o_upd_x,
  output logic [FRAC+1:0]       o_r_out,
  output logic                  o_busy,
  output logic                  o_sweep_done,
  output logic                  o_overrun
);

  localparam int unsigned XW = x_width(FRAC);
  localparam int unsigned RW = r_width(FRAC);
  localparam int unsigned BW = b_width(FRAC);
  localparam int unsigned PW = p_width(FRAC);

  localparam logic [BW-1:0]    C_ONE_B  = BW'(one_val(FRAC));
  localparam logic [RW-1:0]    C_R_INIT = RW'(R_INIT);
  localparam logic [RW:0]      C_R_MAX  = (RW + 1)'(R_MAX);
  localparam logic [RW:0]      C_R_INC  = (RW + 1)'(R_INC);
  localparam logic [IDX_W-1:0] C_LAST   = IDX_W'(N_OSC - 1);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [XW-1:0]    r_x [N_OSC];
  logic [IDX_W-1:0] r_idx;
  logic [XW-1:0]    r_y;
  logic [RW-1:0]    r_r;
  logic             r_mul_req;
  logic [RW-1:0]    r_mul_a;
  logic [BW-1:0]    r_mul_b;
  logic             r_upd_valid;
  logic [IDX_W-1:0] r_upd_idx;
  logic [XW-1:0]    r_upd_x;
  logic             r_busy;
  logic             r_sweep_done;
  logic             r_overrun;

  logic             w_tick;
  logic             w_ack;
  logic [XW-1:0]    w_x_cur;
  logic [XW-1:0]    w_y;
  logic [FRAC+2:0]  w_z_wide;
  logic [XW-1:0]    w_z;
  logic [RW:0]      w_r_sum;
  logic             w_unused_p_lsb;

  logistic_frame_timer #(
    .ITER_LEN (ITER_LEN)
  ) u_timer (
    .clk      (clk),
    .reset    (reset),
    .i_enable (i_enable),
    .o_tick   (w_tick)
  );

  assign w_ack          = i_mul_ack & r_mul_req;
  assign w_x_cur        = r_x[r_idx];
  assign w_y            = i_mul_p[2*FRAC-1:FRAC];
  assign w_z_wide       = i_mul_p[PW-1:FRAC];
  assign w_r_sum        = {1'b0, r_r} + C_R_INC;
  assign w_unused_p_lsb = ^i_mul_p[FRAC-1:0];

  // Saturate to just below 1.0, and never emit 0 (the map's absorbing fixed point).
  always_comb begin
    w_z = w_z_wide[XW-1:0];
    if (|w_z_wide[FRAC+2:FRAC]) begin
      w_z = '1;
    end else if (w_z_wide == '0) begin
      w_z = XW'(1);
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_tick) w_state_nxt = MUL_Y;
      MUL_Y:   if (w_ack)  w_state_nxt = MUL_Z;
      MUL_Z:   if (w_ack)  w_state_nxt = WRITE;
      WRITE:   w_state_nxt = (r_idx == C_LAST) ? R_STEP : MUL_Y;
      R_STEP:  w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  // Each multiply spends one cycle with req low to load operands, then holds req until ack.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < N_OSC; i++) begin
        r_x[i] <= XW'(seed_x(SEED_BASE, SEED_STEP, unsigned'(i), FRAC));
      end
      r_idx        <= '0;
      r_y          <= '0;
      r_r          <= C_R_INIT;
      r_mul_req    <= 1'b0;
      r_mul_a      <= '0;
      r_mul_b      <= '0;
      r_upd_valid  <= 1'b0;
      r_upd_idx    <= '0;
      r_upd_x      <= '0;
      r_busy       <= 1'b0;
      r_sweep_done <= 1'b0;
      r_overrun    <= 1'b0;
    end else begin
      r_upd_valid  <= 1'b0;
      r_sweep_done <= 1'b0;
      if (w_tick && (r_state != IDLE)) r_overrun <= 1'b1;
      case (r_state)
        IDLE: begin
          if (w_tick) begin
            r_busy <= 1'b1;
            r_idx  <= '0;
          end
        end
        MUL_Y: begin
          if (!r_mul_req) begin
            r_mul_req <= 1'b1;
            r_mul_a   <= RW'(w_x_cur);
            r_mul_b   <= C_ONE_B - BW'(w_x_cur);
          end else if (i_mul_ack) begin
            r_mul_req <= 1'b0;
            r_y       <= w_y;
          end
        end
        MUL_Z: begin
          if (!r_mul_req) begin
            r_mul_req <= 1'b1;
            r_mul_a   <= r_r;
            r_mul_b   <= BW'(r_y);
          end else if (i_mul_ack) begin
            r_mul_req    <= 1'b0;
            r_x[r_idx]   <= w_z;
            r_upd_valid  <= 1'b1;
            r_upd_idx    <= r_idx;
            r_upd_x      <= w_z;
          end
        end
        WRITE: begin
          if (r_idx == C_LAST) r_sweep_done <= 1'b1;
          else                 r_idx <= r_idx + IDX_W'(1);
        end
        R_STEP: begin
          r_r    <= (w_r_sum > C_R_MAX) ? C_R_INIT : w_r_sum[RW-1:0];
          r_busy <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign o_mul_req    = r_mul_req;
  assign o_mul_a      = r_mul_a;
  assign o_mul_b      = r_mul_b;
  assign o_upd_valid  = r_upd_valid;
  assign o_upd_idx    = r_upd_idx;
  assign o_upd_x      = r_upd_x;
  assign o_r_out      = r_r;
  assign o_busy       = r_busy;
  assign o_sweep_done = r_sweep_done;
  assign o_overrun    = r_overrun;

endmodule
`default_nettype wire

// File: tb/tb_logistic_iter_sched.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | tb_logistic_iter_sched : directed sequence of sweeps with a randomized   |
// |                          multiplier responder and a reference model.     |
// +-------------------------------------------------------------------------+
module tb_logistic_iter_sched;

  localparam int unsigned N_OSC     = 8;
  localparam int unsigned ITER_LEN  = 16;
  localparam int unsigned FRAC      = 16;
  localparam int unsigned R_INIT    = 32'h30000;
  localparam int unsigned R_MAX     = 32'h30005;
  localparam int unsigned R_INC     = 2;
  localparam int unsigned SEED_BASE = 32'h8000;
  localparam int unsigned SEED_STEP = 32'h2000;
  localparam longint      ONE_M     = 64'd1 << FRAC;

  logic        clk;
  logic        reset;
  logic        enable;
  logic        mul_req;
  logic [17:0] mul_a;
  logic [16:0] mul_b;
  logic        mul_ack;
  logic [34:0] mul_p;
  logic        upd_valid;
  logic [2:0]  upd_idx;
  logic [15:0] upd_x;
  logic [17:0] r_out;
  logic        busy;
  logic        sweep_done;
  logic        overrun;

  int     n_pass  = 0;
  int     n_total = 0;
  longint x_m [N_OSC];
  longint r_m;

  logistic_iter_sched #(
    .N_OSC     (N_OSC),
    .ITER_LEN  (ITER_LEN),
    .FRAC      (FRAC),
    .R_INIT    (R_INIT),
    .R_MAX     (R_MAX),
    .R_INC     (R_INC),
    .SEED_BASE (SEED_BASE),
    .SEED_STEP (SEED_STEP)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .i_enable     (enable),
    .o_mul_req    (mul_req),
    .o_mul_a      (mul_a),
    .o_mul_b      (mul_b),
    .i_mul_ack    (mul_ack),
    .i_mul_p      (mul_p),
    .o_upd_valid  (upd_valid),
    .o_upd_idx    (upd_idx),
    .o_upd_x      (upd_x),
    .o_r_out      (r_out),
    .o_busy       (busy),
    .o_sweep_done (sweep_done),
    .o_overrun    (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: observed no end of test, expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic longint seed_m(input int i);
    longint v;
    v = (longint'(SEED_BASE) + longint'(i) * longint'(SEED_STEP)) % ONE_M;
    return (v == 0) ? 1 : v;
  endfunction

  function automatic longint ref_y(input longint x);
    return ((x * (ONE_M - x)) / ONE_M) % ONE_M;
  endfunction

  function automatic longint ref_z(input longint r, input longint y);
    longint z;
    z = (r * y) / ONE_M;
    if (z > ONE_M - 1) z = ONE_M - 1;
    if (z == 0) z = 1;
    return z;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < N_OSC; i++) x_m[i] = seed_m(i);
    r_m = R_INIT;
  endtask

  task automatic wait_busy(input int bound, output int n);
    n = 0;
    while (busy !== 1'b1 && n < bound) begin
      step();
      n++;
    end
    chk("busy_start_in_time", {63'd0, busy}, 64'd1);
  endtask

  // Acts as the shared multiplier and checks one sweep; entered on the first cycle busy is seen.
  task automatic do_sweep(input int dmin, input int dmax, input bit chk_lat,
                          input bit drop_en, input int abort_phase, output bit aborted);
    int          phase = 0;
    int          upd   = 0;
    int          wcnt  = 0;
    int          steps = 0;
    bit          seen  = 0;
    bit          done  = 0;
    logic [17:0] a0;
    logic [16:0] b0;
    longint      xs, ys;
    aborted = 0;
    if (drop_en) enable = 1'b0;
    while (!done && steps < 3000) begin
      xs = x_m[phase / 2];
      ys = ref_y(xs);
      if (mul_ack) begin
        chk("req_drop_after_ack", {63'd0, mul_req}, 64'd0);
        mul_ack = 1'b0;
        seen    = 0;
        phase++;
      end else if (mul_req) begin
        if (!seen) begin
          if (phase == abort_phase) begin
            reset   = 1'b1;
            mul_ack = 1'b1;
            step();
            chk("rst_req",   {63'd0, mul_req},    64'd0);
            chk("rst_busy",  {63'd0, busy},       64'd0);
            chk("rst_r",     {46'd0, r_out},      64'(R_INIT));
            chk("rst_upd",   {63'd0, upd_valid},  64'd0);
            chk("rst_done",  {63'd0, sweep_done}, 64'd0);
            chk("rst_ovr",   {63'd0, overrun},    64'd0);
            reset   = 1'b0;
            mul_ack = 1'b0;
            model_reset();
            aborted = 1;
            return;
          end
          seen = 1;
          a0   = mul_a;
          b0   = mul_b;
          if (phase % 2 == 0) begin
            chk("opA_x",     {46'd0, mul_a}, 64'(xs));
            chk("opB_1mx",   {47'd0, mul_b}, 64'(ONE_M - xs));
          end else begin
            chk("opA_r",     {46'd0, mul_a}, 64'(r_m));
            chk("opB_y",     {47'd0, mul_b}, 64'(ys));
          end
          wcnt = $urandom_range(dmax, dmin) - 1;
        end else begin
          chk("hold_a", {46'd0, mul_a}, {46'd0, a0});
          chk("hold_b", {47'd0, mul_b}, {47'd0, b0});
        end
        if (wcnt == 0) begin
          mul_ack = 1'b1;
          mul_p   = {17'd0, a0} * {18'd0, b0};
        end else begin
          wcnt--;
        end
      end
      if (upd_valid) begin
        if (chk_lat && upd == 0) chk("lat_first_upd", 64'(steps), 64'd4);
        chk("upd_idx", {61'd0, upd_idx}, 64'(upd));
        chk("upd_x",   {48'd0, upd_x},   64'(ref_z(r_m, ref_y(x_m[upd]))));
        x_m[upd] = ref_z(r_m, ref_y(x_m[upd]));
        upd++;
      end
      if (sweep_done) begin
        chk("upd_count", 64'(upd), 64'(N_OSC));
        chk("r_during_sweep", {46'd0, r_out}, 64'(r_m));
        if (chk_lat) chk("lat_sweep", 64'(steps), 64'd40);
        done = 1;
      end else begin
        step();
        steps++;
      end
    end
    chk("sweep_completed", {63'd0, done}, 64'd1);
    step();
    r_m = (r_m + R_INC > R_MAX) ? longint'(R_INIT) : r_m + R_INC;
    chk("r_after_sweep", {46'd0, r_out}, 64'(r_m));
    chk("busy_cleared",  {63'd0, busy}, 64'd0);
    chk("done_one_pulse", {63'd0, sweep_done}, 64'd0);
    if (drop_en) enable = 1'b1;
  endtask

  initial begin
    int n;
    int busy_seen;
    bit ab;
    reset   = 1'b1;
    enable  = 1'b0;
    mul_ack = 1'b0;
    mul_p   = '0;
    model_reset();
    repeat (3) step();
    chk("reset_req",   {63'd0, mul_req},    64'd0);
    chk("reset_a",     {46'd0, mul_a},      64'd0);
    chk("reset_b",     {47'd0, mul_b},      64'd0);
    chk("reset_upd",   {63'd0, upd_valid},  64'd0);
    chk("reset_idx",   {61'd0, upd_idx},    64'd0);
    chk("reset_x",     {48'd0, upd_x},      64'd0);
    chk("reset_busy",  {63'd0, busy},       64'd0);
    chk("reset_done",  {63'd0, sweep_done}, 64'd0);
    chk("reset_ovr",   {63'd0, overrun},    64'd0);
    chk("reset_r",     {46'd0, r_out},      64'(R_INIT));

    reset  = 1'b0;
    enable = 1'b1;
    wait_busy(200, n);
    chk("first_tick_delay", 64'(n), 64'(ITER_LEN));
    chk("ovr_before_tick", {63'd0, overrun}, 64'd0);
    do_sweep(1, 1, 1, 0, -1, ab);
    chk("ovr_sticky_set", {63'd0, overrun}, 64'd1);

    enable  = 1'b0;
    mul_ack = 1'b1;
    mul_p   = '1;
    step();
    mul_ack = 1'b0;
    chk("stray_ack_req", {63'd0, mul_req},   64'd0);
    chk("stray_ack_upd", {63'd0, upd_valid}, 64'd0);
    busy_seen = 0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (busy === 1'b1 || upd_valid === 1'b1) busy_seen++;
    end
    chk("frozen_timer_no_sweep", 64'(busy_seen), 64'd0);
    enable = 1'b1;

    wait_busy(3 * ITER_LEN + 50, n);
    do_sweep(7, 7, 0, 1, -1, ab);
    wait_busy(3 * ITER_LEN + 50, n);
    do_sweep(1, 4, 0, 0, -1, ab);
    chk("r_wrapped", {46'd0, r_out}, 64'(R_INIT));
    wait_busy(3 * ITER_LEN + 50, n);
    do_sweep(1, 3, 0, 0, -1, ab);

    wait_busy(3 * ITER_LEN + 50, n);
    do_sweep(1, 3, 0, 0, 7, ab);
    chk("reset_abort_taken", {63'd0, ab}, 64'd1);
    wait_busy(200, n);
    chk("tick_after_midreset", 64'(n), 64'(ITER_LEN));
    do_sweep(1, 2, 0, 0, -1, ab);
    chk("ovr_after_reset_sweep", {63'd0, overrun}, 64'd1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/logistic_iter_sched.md
Name: logistic_iter_sched

Overview:
- Sequences the logistic-map update x' = r·x·(1−x) for every oscillator slot of the logistic sound generator, once per iteration frame of ITER_LEN clocks.
- Owns the per-slot x state and the shared growth rate r. Time-multiplexes one external shared multiplier through a req/ack handshake.
- Publishes each new x value on an update strobe that the oscillator bank consumes to retune its phase increments.

Parameters:
- N_OSC, 8, number of oscillator slots, ≥1.
- ITER_LEN, 15361, clocks per iteration frame; must exceed the worst-case sweep length.
- FRAC, 16, fractional bits of x; r is unsigned Q2.FRAC.
- R_INIT, 3<<FRAC (0x30000), value of r after reset and after wrap.
- R_MAX, (4<<FRAC)−1, highest legal value of r.
- R_INC, 2, amount added to r after each completed sweep.
- SEED_BASE, 0x8000, initial value of x[0].
- SEED_STEP, 0x0101, initial x[i] = (SEED_BASE + i·SEED_STEP) mod 2^FRAC; a zero result is replaced by 1.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high.
- enable  in  1  frame timer runs while high.
- mul_req  out  1  multiplier request.
- mul_a  out  FRAC+2  multiplier operand A.
- mul_b  out  FRAC+1  multiplier operand B.
- mul_ack  in  1  multiplier acknowledge; mul_p is valid in this cycle.
- mul_p  in  2·FRAC+3  unsigned product.
- upd_valid  out  1  one-cycle strobe: new x available.
- upd_idx  out  clog2(N_OSC) (minimum 1)  slot index of the update.
- upd_x  out  FRAC  new x value.
- r_out  out  FRAC+2  current r.
- busy  out  1  a sweep is in progress.
- sweep_done  out  1  one-cycle strobe at the end of each sweep.
- overrun  out  1  sticky: a frame tick arrived while busy.

Behaviour:
- Reset values:
  - mul_req, mul_a, mul_b, upd_valid, upd_idx, upd_x, busy, sweep_done, overrun all 0.
  - r_out = R_INIT.
  - x[i] = seed values.
  - Frame counter = 0, FSM = IDLE.
- Reset asserted mid-sweep: everything returns to reset values on that edge and any pending mul_req is dropped. mul_ack arriving while reset is high is ignored.
- Frame timer:
  - Counts 0..ITER_LEN−1 while enable=1 and holds its value while enable=0.
  - Terminal count raises tick for one cycle.
  - tick while IDLE starts a sweep.
  - tick while not IDLE sets overrun and is dropped.
  - Deasserting enable mid-sweep does not abort the sweep.
- FSM:
  - IDLE: on tick, set busy=1, idx=0 → MUL_Y.
  - MUL_Y: mul_req=1, mul_a = zero-extended x[idx], mul_b = 2^FRAC − x[idx]. On mul_ack: y = mul_p[2·FRAC−1:FRAC] (FRAC bits, truncated), drop mul_req → MUL_Z.
  - MUL_Z: mul_req=1, mul_a = r, mul_b = zero-extended y. On mul_ack: z = mul_p >> FRAC, clamped to 2^FRAC−1; if z == 0 then z = 1 (avoids the fixed point) → WRITE.
  - WRITE: x[idx] = z; upd_valid=1, upd_idx=idx, upd_x=z for exactly one cycle. If idx == N_OSC−1 → R_STEP, else idx+1 → MUL_Y.
  - R_STEP: if r + R_INC > R_MAX then r = R_INIT, else r = r + R_INC. Pulse sweep_done; busy=0 → IDLE.
- Handshake rules:
  - mul_req is registered. Operands stay stable while mul_req=1.
  - mul_req deasserts the cycle after mul_ack is sampled.
  - mul_ack is ignored when mul_req=0.
  - There is no timeout; the FSM waits indefinitely.
- Latency:
  - With mul_ack one cycle after mul_req rises: 5 cycles per slot.
  - Sweep = 5·N_OSC+1 cycles from tick to sweep_done, i.e. 41 cycles for N_OSC=8.
  - The first upd_valid occurs 5 cycles after tick.
- Arithmetic: all unsigned; no rounding; widths exactly as stated above.
- r update timing: r_out changes only in R_STEP, so every slot within one sweep uses the same r.

Decomposition:
- Package logistic_pkg:
  - FSM state enum (IDLE, MUL_Y, MUL_Z, WRITE, R_STEP).
  - ONE = 1<<FRAC.
  - Width functions for x, r and the product.
  - Seed computation function.
- Sub-module logistic_frame_timer: ports clk, reset, enable, tick. Parameter ITER_LEN.

Test Plan:
- FRAC=16, r=0x30000, x[0]=0x8000, ack 1 cycle after req → slot 0 produces y=0x4000 and upd_x=0xC000; upd_valid rises 5 cycles after tick.
- Seed x=0x0001 → y=0, z forced to 1; upd_x=0x0001.
- ITER_LEN=16, N_OSC=8 (sweep of 41 cycles) → second tick lands while busy; overrun=1 and stays set; only one sweep_done per sweep.
- r=R_MAX−1 with R_INC=2 → after sweep_done, r_out=0x30000 (wrap); with r=0x30000 → r_out=0x30002.
- mul_ack delayed 7 cycles → mul_req and mul_a/mul_b hold stable the whole time; mul_req drops the cycle after ack; a stray mul_ack while in IDLE is ignored with no upd_valid.
- Reset pulsed mid-MUL_Z of slot 3 → next cycle mul_req=0, busy=0, r_out=0x30000, seeds restored; the next tick comes ITER_LEN cycles after reset release.
